// File: rtl/phase_sequencer.sv
// One-hot instruction phase sequencer with debounced run/step buttons, datapath halt and a retired-instruction counter.
// Optional build macro PHASE_OVERLAP_EN: in RUN, the last phase of an instruction overlaps bit 0 of the next.
module phase_sequencer #(
    parameter int NPHASE      = 5,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 16,
    parameter int AUTO_RUN    = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              run_btn,
    input  logic              step_btn,
    input  logic              halt,
    input  logic [1:0]        mode,
    input  logic [NPHASE-1:0] skip_mask,
    output logic [NPHASE-1:0] phase,
    output logic              running,
    output logic              instr_done,
    output logic [CNT_W-1:0]  instr_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_STOPPING,
        S_STEP,
        S_HALTED
    } state_t;

    typedef enum logic [1:0] {
        M_FREE  = 2'b00,
        M_PHASE = 2'b01,
        M_INSTR = 2'b10,
        M_ALT   = 2'b11
    } mode_t;

    localparam logic [NPHASE-1:0] BIT0 = NPHASE'(1);

    // Index of the highest set bit; 0 for an empty vector.
    function automatic int top_bit(input logic [NPHASE-1:0] v);
        int idx;
        idx = 0;
        for (int i = 0; i < NPHASE; i++)
            if (v[i]) idx = i;
        return idx;
    endfunction

    // Index of the nearest active phase above 'from'; 0 means the instruction wraps.
    function automatic int next_bit(input int from, input logic [NPHASE-1:0] act);
        int idx;
        idx = 0;
        for (int i = NPHASE - 1; i > 0; i--)
            if (i > from && act[i]) idx = i;
        return idx;
    endfunction

    logic [SYNC_STAGES-1:0] r_run_sync;
    logic [SYNC_STAGES-1:0] r_step_sync;
    logic                   r_run_last;
    logic                   r_step_last;
    logic                   w_run_press;
    logic                   w_step_press;

    state_t            r_state;
    state_t            w_state_nxt;
    mode_t             r_mode;
    mode_t             w_mode_nxt;
    logic [NPHASE-1:0] r_phase;
    logic [NPHASE-1:0] w_phase_nxt;
    logic [CNT_W-1:0]  r_count;

    logic [NPHASE-1:0] w_active;
    logic [NPHASE-1:0] w_adv;
    logic              w_overlap;
    logic              w_last;
    int                w_top;
    int                w_from;
    int                w_adv_idx;
`ifdef PHASE_OVERLAP_EN
    logic              w_adv_last;
`endif

    // Buttons idle high; a press is the first cycle the synchronised level reads low.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_run_sync  <= '1;
            r_step_sync <= '1;
            r_run_last  <= 1'b1;
            r_step_last <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values; blocking here would collapse the synchroniser chain.
            r_run_sync  <= {r_run_sync[SYNC_STAGES-2:0], run_btn};
            r_step_sync <= {r_step_sync[SYNC_STAGES-2:0], step_btn};
            r_run_last  <= r_run_sync[SYNC_STAGES-1];
            r_step_last <= r_step_sync[SYNC_STAGES-1];
        end
    end

    assign w_run_press  = r_run_last  & ~r_run_sync[SYNC_STAGES-1];
    assign w_step_press = r_step_last & ~r_step_sync[SYNC_STAGES-1];

    // An overlapped vector (bit 0 plus the old last phase) advances as if it were bit 0.
    always_comb begin
        w_active  = ~skip_mask | BIT0;
        w_top     = top_bit(r_phase);
        w_overlap = r_phase[0] && (r_phase[NPHASE-1:1] != '0);
        w_from    = w_overlap ? 0 : w_top;
        w_adv_idx = next_bit(w_from, w_active);
        w_adv     = BIT0 << w_adv_idx;
        w_last    = (r_phase != '0) && (next_bit(w_top, w_active) == 0);
`ifdef PHASE_OVERLAP_EN
        w_adv_last = (next_bit(w_adv_idx, w_active) == 0);
`endif
    end

    always_comb begin
        // NOTE: every variable gets a default before the case so no path leaves it unassigned and infers a latch.
        w_state_nxt = r_state;
        w_phase_nxt = r_phase;
        w_mode_nxt  = r_mode;
        if (halt) begin
            w_state_nxt = S_HALTED;
            w_phase_nxt = '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    w_phase_nxt = '0;
                    if (w_run_press) begin
                        w_state_nxt = S_RUN;
                        w_phase_nxt = BIT0;
                        w_mode_nxt  = mode_t'(mode);
                    end else if (w_step_press &&
                                 (mode_t'(mode) == M_PHASE || mode_t'(mode) == M_INSTR)) begin
                        w_state_nxt = S_STEP;
                        w_phase_nxt = BIT0;
                        w_mode_nxt  = mode_t'(mode);
                    end
                end
                S_RUN: begin
                    if (w_run_press) begin
                        w_state_nxt = S_STOPPING;
                        if (r_phase == '0 || (w_last && !w_overlap))
                            w_phase_nxt = '0;
                        else
                            w_phase_nxt = w_adv;
                    end else if (r_phase == '0) begin
                        w_phase_nxt = BIT0;
                    end else begin
                        w_phase_nxt = w_adv;
`ifdef PHASE_OVERLAP_EN
                        if (w_adv_last && w_adv_idx != 0)
                            w_phase_nxt = w_adv | BIT0;
`endif
                    end
                end
                S_STOPPING: begin
                    if (r_phase == '0 || w_last) begin
                        w_state_nxt = S_IDLE;
                        w_phase_nxt = '0;
                    end else begin
                        w_phase_nxt = w_adv;
                    end
                end
                S_STEP: begin
                    if (r_mode == M_INSTR || w_step_press) begin
                        if (w_last) begin
                            w_state_nxt = S_IDLE;
                            w_phase_nxt = '0;
                        end else begin
                            w_phase_nxt = w_adv;
                        end
                    end
                end
                S_HALTED: begin
                    w_phase_nxt = '0;
                    if (w_run_press) begin
                        w_state_nxt = S_RUN;
                        w_phase_nxt = BIT0;
                        w_mode_nxt  = mode_t'(mode);
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_phase_nxt = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= (AUTO_RUN != 0) ? S_RUN : S_IDLE;
            r_mode  <= M_FREE;
            r_phase <= '0;
            r_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_mode  <= w_mode_nxt;
            r_phase <= w_phase_nxt;
            if (w_last && !halt)
                r_count <= r_count + 1'b1;
        end
    end

    assign phase       = r_phase;
    assign running     = (r_state == S_RUN) || (r_state == S_STEP);
    assign instr_done  = w_last;
    assign instr_count = r_count;

endmodule

// File: tb/tb_phase_sequencer.sv
// Directed bench for phase_sequencer: auto-run, skip, stop, both step modes, halt, reset abort, counter wrap, press priority.
// Built with PHASE_OVERLAP_EN it checks the overlapped phase pattern instead.
module tb_phase_sequencer;

    localparam int NPHASE = 5;
    localparam int CNT_W  = 3;

    logic              clock;
    logic              reset;
    logic              run_btn;
    logic              step_btn;
    logic              halt;
    logic [1:0]        mode;
    logic [NPHASE-1:0] skip_mask;
    logic [NPHASE-1:0] phase;
    logic              running;
    logic              instr_done;
    logic [CNT_W-1:0]  instr_count;

    int n_checks = 0;
    int n_fail   = 0;
    int waited;

    phase_sequencer #(
        .NPHASE     (NPHASE),
        .SYNC_STAGES(2),
        .CNT_W      (CNT_W),
        .AUTO_RUN   (1)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .run_btn    (run_btn),
        .step_btn   (step_btn),
        .halt       (halt),
        .mode       (mode),
        .skip_mask  (skip_mask),
        .phase      (phase),
        .running    (running),
        .instr_done (instr_done),
        .instr_count(instr_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic tick_phase(input string tag, input logic [NPHASE-1:0] exp);
        @(negedge clock);
        check(tag, 32'(phase), 32'(exp));
    endtask

    // Holds the chosen buttons low for three cycles; the resulting transition is visible on return.
    task automatic press(input logic run, input logic step);
        run_btn  = !run;
        step_btn = !step;
        repeat (3) @(negedge clock);
        run_btn  = 1'b1;
        step_btn = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        reset     = 1'b0;
        run_btn   = 1'b1;
        step_btn  = 1'b1;
        halt      = 1'b0;
        mode      = 2'b00;
        skip_mask = '0;
        repeat (2) @(negedge clock);
        check("rst_phase", 32'(phase), 0);
        check("rst_done", 32'(instr_done), 0);
        check("rst_count", 32'(instr_count), 0);
        reset = 1'b1;

`ifdef PHASE_OVERLAP_EN
        tick_phase("ov_p0", 5'b00001);
        tick_phase("ov_p1", 5'b00010);
        tick_phase("ov_p2", 5'b00100);
        tick_phase("ov_p3", 5'b01000);
        tick_phase("ov_p4", 5'b10001);
        check("ov_done", 32'(instr_done), 1);
        tick_phase("ov_p5", 5'b00010);
        check("ov_cnt1", 32'(instr_count), 1);
        tick_phase("ov_p6", 5'b00100);
        tick_phase("ov_p7", 5'b01000);
        tick_phase("ov_p8", 5'b10001);
        tick_phase("ov_p9", 5'b00010);
        check("ov_cnt2", 32'(instr_count), 2);
`else
        // Auto-run out of reset
        tick_phase("ar_p0", 5'b00001);
        tick_phase("ar_p1", 5'b00010);
        tick_phase("ar_p2", 5'b00100);
        tick_phase("ar_p3", 5'b01000);
        tick_phase("ar_p4", 5'b10000);
        check("ar_done", 32'(instr_done), 1);
        tick_phase("ar_wrap", 5'b00001);
        check("ar_count", 32'(instr_count), 1);

        // Skipped phase
        skip_mask = 5'b01000;
        tick_phase("sk_p1", 5'b00010);
        tick_phase("sk_p2", 5'b00100);
        check("sk_done_mid", 32'(instr_done), 0);
        tick_phase("sk_p4", 5'b10000);
        check("sk_done", 32'(instr_done), 1);
        tick_phase("sk_wrap", 5'b00001);
        skip_mask = '0;
        check("sk_count", 32'(instr_count), 2);

        // Stop request lands while phase 00010 is active
        tick_phase("st_a1", 5'b00010);
        tick_phase("st_a2", 5'b00100);
        tick_phase("st_a3", 5'b01000);
        tick_phase("st_a4", 5'b10000);
        run_btn = 1'b0;
        tick_phase("st_b0", 5'b00001);
        check("st_count3", 32'(instr_count), 3);
        tick_phase("st_b1", 5'b00010);
        tick_phase("st_b2", 5'b00100);
        run_btn = 1'b1;
        tick_phase("st_b3", 5'b01000);
        tick_phase("st_b4", 5'b10000);
        check("st_done", 32'(instr_done), 1);
        tick_phase("st_idle0", 5'b00000);
        check("st_running", 32'(running), 0);
        tick_phase("st_idle1", 5'b00000);
        check("st_count4", 32'(instr_count), 4);

        // Step-phase mode; the later mode change must not take effect mid-instruction
        mode = 2'b01;
        press(1'b0, 1'b1);
        check("sp_p0", 32'(phase), 1);
        check("sp_running", 32'(running), 1);
        mode = 2'b10;
        repeat (3) @(negedge clock);
        check("sp_hold0", 32'(phase), 1);
        for (int i = 1; i < NPHASE; i++) begin
            press(1'b0, 1'b1);
            check($sformatf("sp_p%0d", i), 32'(phase), 32'(1) << i);
            repeat (3) @(negedge clock);
            check($sformatf("sp_hold%0d", i), 32'(phase), 32'(1) << i);
        end
        press(1'b0, 1'b1);
        check("sp_idle", 32'(phase), 0);
        check("sp_running_off", 32'(running), 0);
        repeat (3) @(negedge clock);

        // Step-instruction mode
        press(1'b0, 1'b1);
        check("si_p0", 32'(phase), 1);
        tick_phase("si_p1", 5'b00010);
        check("si_running", 32'(running), 1);
        tick_phase("si_p2", 5'b00100);
        tick_phase("si_p3", 5'b01000);
        tick_phase("si_p4", 5'b10000);
        tick_phase("si_idle", 5'b00000);

        // Halt, presses ignored while halted, resume with run
        mode = 2'b00;
        press(1'b1, 1'b0);
        check("h_p0", 32'(phase), 1);
        tick_phase("h_p1", 5'b00010);
        tick_phase("h_p2", 5'b00100);
        halt = 1'b1;
        tick_phase("h_zero", 5'b00000);
        check("h_running", 32'(running), 0);
        press(1'b1, 1'b0);
        check("h_ignored", 32'(phase), 0);
        repeat (3) @(negedge clock);
        check("h_still", 32'(phase), 0);
        halt = 1'b0;
        tick_phase("h_hold", 5'b00000);
        press(1'b1, 1'b0);
        check("h_resume", 32'(phase), 1);
        tick_phase("h_next", 5'b00010);

        // Asynchronous reset mid-instruction
        tick_phase("ra_pre", 5'b00100);
        reset = 1'b0;
        #1;
        check("ra_phase", 32'(phase), 0);
        check("ra_done", 32'(instr_done), 0);
        check("ra_count", 32'(instr_count), 0);
        @(negedge clock);
        reset = 1'b1;

        // Counter wraps from 7 to 0 with a 3-bit counter
        for (int k = 1; k <= 41; k++) begin
            @(negedge clock);
            if (k == 36) check("wr_cnt7", 32'(instr_count), 7);
            if (k == 41) begin
                check("wr_cnt0", 32'(instr_count), 0);
                check("wr_phase", 32'(phase), 1);
            end
        end

        // Stop again, bounded wait for idle
        press(1'b1, 1'b0);
        waited = 0;
        while (phase != '0 && waited < 20) begin
            @(negedge clock);
            waited++;
        end
        check("sb_idle", 32'(phase), 0);
        check("sb_running", 32'(running), 0);
        repeat (3) @(negedge clock);

        // Simultaneous presses: run wins, so the phase keeps moving
        mode = 2'b01;
        press(1'b1, 1'b1);
        check("sim_p0", 32'(phase), 1);
        check("sim_running", 32'(running), 1);
        tick_phase("sim_p1", 5'b00010);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/phase_sequencer.md
PHASE_SEQUENCER -- requirements
Module: phase_sequencer

Interface
REQ-001 Parameter NPHASE, default 5: number of one-hot phases per instruction, legal range 3..16.
REQ-002 Parameter SYNC_STAGES, default 2: synchroniser depth for button inputs, legal range 2..4.
REQ-003 Parameter CNT_W, default 16: width of the retired-instruction counter.
REQ-004 Parameter AUTO_RUN, default 1: when 1, the sequencer leaves reset running.
REQ-005 clock  in  1  system clock; all state changes on the rising edge.
REQ-006 reset  in  1  asynchronous, active-low.
REQ-007 run_btn  in  1  asynchronous active-low button; each press toggles run/stop.
REQ-008 step_btn  in  1  asynchronous active-low button; each press requests one step.
REQ-009 halt  in  1  synchronous, active-high halt from the datapath.
REQ-010 mode  in  2  00 free-run, 01 step-phase, 10 step-instruction, 11 treated as 00.
REQ-011 skip_mask  in  NPHASE  bit i=1 skips phase i; bit 0 is ignored.
REQ-012 phase  out  NPHASE  one-hot phase vector; bit 0 is fetch; all zero when idle.
REQ-013 running  out  1  high in RUN and STEP states.
REQ-014 instr_done  out  1  high during every cycle in which the last active phase of an instruction is asserted.
REQ-015 instr_count  out  CNT_W  count of completed instructions.

Function
REQ-016 Each button SHALL pass through a SYNC_STAGES flop synchroniser, then a 1->0 edge detector; one press produces exactly one single-cycle press pulse.
REQ-017 The FSM SHALL have exactly five states: IDLE, RUN, STOPPING, STEP, HALTED.
REQ-018 IDLE: phase=0; a run press enters RUN with phase bit 0 asserted in the next cycle; a step press with mode 01 or 10 enters STEP at phase bit 0.
REQ-019 RUN: phase advances every cycle from bit i to the next higher bit j with skip_mask[j]=0 (sampled that cycle); after the last unskipped phase, phase wraps to bit 0.
REQ-020 RUN with a run press SHALL enter STOPPING; STOPPING completes the current instruction, then goes to IDLE with phase=0.
REQ-021 STEP, mode 01: the phase is held until a step press, then advances one position under the REQ-019 rules; completing the last phase returns to IDLE.
REQ-022 STEP, mode 10: the FSM runs one full instruction at one phase per cycle, then returns to IDLE.
REQ-023 mode SHALL be sampled only on entry to RUN or STEP; changes mid-instruction have no effect.
REQ-024 halt=1 in any state SHALL force phase=0 and the HALTED state in the next cycle; halt has priority over all presses.
REQ-025 HALTED: only a run press with halt=0, or reset, exits; a run press enters RUN at phase bit 0.
REQ-026 Simultaneous run and step presses: the run press wins and the step press is discarded.
REQ-027 instr_count SHALL increment in each cycle where instr_done=1 and halt=0, and SHALL wrap from all-ones to 0.
REQ-028 At most one phase bit is set at any time, except as permitted by REQ-032.

Reset
REQ-029 While reset is low: phase=0, instr_done=0, instr_count=0, all synchroniser and edge flops=1.
REQ-030 On reset release, the FSM enters RUN if AUTO_RUN=1, otherwise IDLE; with AUTO_RUN=1, phase bit 0 is asserted in the first clock after release.
REQ-031 Reset asserted mid-instruction SHALL abort immediately; no instr_done pulse or count is generated.

Configuration
REQ-032 With PHASE_OVERLAP_EN defined, in RUN only, the last phase of an instruction is asserted together with bit 0 of the next instruction; the next cycle advances directly past bit 0 to the next unskipped phase.
REQ-033 Without PHASE_OVERLAP_EN, the phase vector is strictly one-hot, with bit 0 in its own cycle.

Verification
REQ-034 Reset release with AUTO_RUN=1, NPHASE=5, skip_mask=0 -> phase 00001,00010,00100,01000,10000,00001; instr_count=1 at the wrap.
REQ-035 skip_mask=5'b01000 in RUN -> phase 00100 is followed directly by 10000; instr_done high with 10000.
REQ-036 Run press while phase=00010 -> continues 00100,01000,10000, then 00000 held; running=0.
REQ-037 mode=01 from IDLE, four step presses -> phase 00001 -> 00010 -> 00100 -> 01000 -> 10000, each held between presses; one more press -> IDLE.
REQ-038 halt pulse at phase 00100 -> 00000 next cycle, HALTED; presses ignored while halt=1; a run press after halt drops -> 00001.
REQ-039 With PHASE_OVERLAP_EN defined, steady RUN -> 00010,00100,01000,10001,00010; instr_count increments per 4-cycle loop.
